fir_axis_requant: RTL and testbench
===================================

Name: fir_axis_requant

Overview:
- Downstream output stage of the 15-tap FIR. It consumes the filter's 32-bit signed accumulator stream and produces a 16-bit Q1.15 AXI-Stream.
- Applies shift, round-half-up and saturation, then buffers results in a 2-entry skid FIFO so downstream backpressure reaches the filter.
- Measures accepted-beat throughput over a fixed window and reports a 2-bit load level for the DVS voltage selector.

Parameters:
- IN_W, 32, input sample width (signed).
- OUT_W, 16, output sample width (signed).
- SHIFT, 15, right-shift applied before rounding. Range 1..IN_W-OUT_W.
- WINDOW, 256, load-measurement window in clock cycles. Power of two, at least 4.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- s_axis_tdata  in  32  signed FIR accumulator sample
- s_axis_tvalid  in  1  input beat valid
- s_axis_tlast  in  1  input end of packet
- s_axis_tready  out  1  block can accept a beat
- m_axis_tdata  out  16  requantised signed sample
- m_axis_tvalid  out  1  output beat valid
- m_axis_tlast  out  1  tlast carried through with its sample
- m_axis_tkeep  out  2  always 2'b11 while m_axis_tvalid is high, else 2'b00
- m_axis_tready  in  1  downstream accepts
- sat_flag  out  1  sticky: set when any accepted sample saturated
- load_level  out  2  throughput level from the last completed window

Behaviour:
- Reset: one clock; reset is asynchronous and active-high (ports clk, reset). Asserting reset clears FIFO count, pointers, sat_flag, load_level, window counter and beat counter immediately, mid-operation included. While reset is high, all outputs read 0 except s_axis_tready, which reads 0 and rises on the first clk edge after reset deasserts. Any in-flight beats are discarded.
- Requant arithmetic (combinational, on the input side):
  - t = sign-extend(s_axis_tdata) to IN_W+1 bits, plus 2^(SHIFT-1).
  - r = t >>> SHIFT, arithmetic shift.
  - If r > 32767, output 32767; if r < -32768, output -32768; otherwise output r[15:0].
  - The sum must not overflow at the 0x7FFFFFFF input.
- Handshake:
  - Accept when s_axis_tvalid && s_axis_tready.
  - The accepted {data, tlast} is written into a 2-entry FIFO.
  - Pop when m_axis_tvalid && m_axis_tready.
  - s_axis_tready is registered and equals (next count < 2).
  - m_axis_tvalid = (count != 0). m_axis_tdata and m_axis_tlast come from the FIFO head register.
- Latency: a beat accepted at edge N into an empty FIFO is presented on m_axis from edge N (visible in cycle N+1), i.e. one cycle.
- Simultaneous push and pop at count 1: count stays 1 and the head advances. No bubble when m_axis_tready is held high, so throughput is 1 beat/clk.
- Full (count 2): s_axis_tready is 0. On a pop, count goes to 1 and s_axis_tready rises in the next cycle.
- Empty: pop is impossible because m_axis_tvalid is 0.
- Data stability: m_axis_tdata and m_axis_tlast hold stable while m_axis_tvalid && !m_axis_tready.
- sat_flag: set in the cycle after an accepted beat saturated. Cleared only by reset.
- Load monitor:
  - win_cnt counts 0..WINDOW-1 and wraps. beat_cnt counts accepted beats (width log2(WINDOW)+1).
  - At the wrap edge: load_level <= 3 if beat_cnt_incl ≥ WINDOW, else beat_cnt_incl[log2W-1:log2W-2]. beat_cnt then restarts from 0, plus the current-cycle beat if one occurs.
  - beat_cnt_incl is the count including a beat accepted in the wrap cycle.
  - load_level updates once per window.

Decomposition:
- Shared package fir_pkg holds the Q-format constants (IN_W, OUT_W, SHIFT defaults), the Q15_MAX/Q15_MIN constants, and the load_level encoding (LOW=0, MED=1, HIGH=2, MAX=3), which it shares with the DVS selector.
- One sub-module, axis_skid_fifo2: the 2-entry FIFO with its registered ready, parameterised on payload width (here 17 = data + tlast).
- Requant arithmetic and the load monitor remain in the top.

Test Plan:
- Rounding, with m_axis_tready=1:
  - inputs 0x00004000, 0x00003FFF, 0xFFFFC000, 0x00008000 → outputs 0x0001, 0x0000, 0x0000, 0x0001
  - each output one cycle after acceptance, sat_flag stays 0
- Saturation: input 0x40000000 → 0x7FFF. Then 0xBFFF0000 → 0x8000. Then 0xC0000000 → 0x8000. sat_flag = 1 after the first beat and stays 1.
- Backpressure:
  - Hold m_axis_tready=0 and drive 3 valid beats A, B, C. A and B are accepted, then s_axis_tready=0 with C held.
  - Raise tready: outputs appear in order A, B, C with no loss or duplication, and tlast on C only is preserved.
- Streaming: 1000 random beats with tvalid and tready both 1 → one output per clock, values match a reference model, tkeep = 2'b11 on every beat.
- Load monitor, WINDOW=256:
  - continuous valid → load_level=3 after the first window
  - valid 1 of every 2 cycles → 2
  - 1 of every 4 cycles → 1
  - idle → 0
- Reset mid-stream: assert reset asynchronously with the FIFO full → m_axis_tvalid=0, load_level=0 and sat_flag=0 immediately. s_axis_tready=1 on the first edge after release, and the first post-reset sample is output correctly.

Source files
------------

// File: rtl/fir_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fir_pkg: Q-format constants and load-level encoding for the FIR back end |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package fir_pkg;

  localparam int FIR_IN_W  = 32;
  localparam int FIR_OUT_W = 16;
  localparam int FIR_SHIFT = 15;

  localparam logic signed [15:0] Q15_MAX = 16'sh7FFF;
  localparam logic signed [15:0] Q15_MIN = 16'sh8000;

  // Shared with the DVS voltage selector.
  typedef enum logic [1:0] {
    LOAD_LOW  = 2'd0,
    LOAD_MED  = 2'd1,
    LOAD_HIGH = 2'd2,
    LOAD_MAX  = 2'd3
  } load_level_e;

endpackage
`default_nettype wire

// File: rtl/axis_skid_fifo2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axis_skid_fifo2: 2-entry stream FIFO with registered ready               |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module axis_skid_fifo2 #(
  parameter int DATA_W = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_valid_o,
  input  logic              m_ready_i
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              ready_q, ready_d;
  logic              push_w, pop_w;

  always_comb begin
    push_w   = s_valid_i && ready_q;
    pop_w    = (count_q != 2'd0) && m_ready_i;
    count_d  = count_q + {1'b0, push_w} - {1'b0, pop_w};
    wr_ptr_d = wr_ptr_q ^ push_w;
    rd_ptr_d = rd_ptr_q ^ pop_w;
    // Ready looks one cycle ahead so it can come straight from a flop.
    ready_d  = (count_d < 2'd2);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      ready_q  <= 1'b0;
    end else begin
      if (push_w) mem_q[wr_ptr_q] <= s_data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end

  assign s_ready_o = ready_q;
  assign m_valid_o = (count_q != 2'd0);
  assign m_data_o  = mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/fir_axis_requant.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fir_axis_requant: FIR accumulator -> Q1.15 AXI-Stream with load monitor  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fir_axis_requant
  import fir_pkg::*;
#(
  parameter int IN_W   = FIR_IN_W,
  parameter int OUT_W  = FIR_OUT_W,
  parameter int SHIFT  = FIR_SHIFT,
  parameter int WINDOW = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  s_axis_tdata,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tlast,
  output logic             s_axis_tready,
  output logic [OUT_W-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  output logic [1:0]       m_axis_tkeep,
  input  logic             m_axis_tready,
  output logic             sat_flag,
  output logic [1:0]       load_level
);

  localparam int LOG2W = $clog2(WINDOW);
  localparam logic [IN_W:0] RND = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [IN_W:0] R_MAX = {{(IN_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] R_MIN = {{(IN_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [IN_W:0] t_w, r_w;
  logic [OUT_W-1:0]     q_w;
  logic                 sat_w;
  logic                 accept_w;

  // One guard bit keeps the rounding add from wrapping at the positive limit.
  always_comb begin
    t_w   = $signed({s_axis_tdata[IN_W-1], s_axis_tdata}) + $signed(RND);
    r_w   = t_w >>> SHIFT;
    q_w   = r_w[OUT_W-1:0];
    sat_w = 1'b0;
    if (r_w > R_MAX) begin
      q_w   = {1'b0, {(OUT_W-1){1'b1}}};
      sat_w = 1'b1;
    end else if (r_w < R_MIN) begin
      q_w   = {1'b1, {(OUT_W-1){1'b0}}};
      sat_w = 1'b1;
    end
  end

  assign accept_w = s_axis_tvalid && s_axis_tready;

  axis_skid_fifo2 #(
    .DATA_W (OUT_W + 1)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .s_data_i  ({s_axis_tlast, q_w}),
    .s_valid_i (s_axis_tvalid),
    .s_ready_o (s_axis_tready),
    .m_data_o  ({m_axis_tlast, m_axis_tdata}),
    .m_valid_o (m_axis_tvalid),
    .m_ready_i (m_axis_tready)
  );

  assign m_axis_tkeep = {2{m_axis_tvalid}};

  logic [LOG2W-1:0] win_cnt_q, win_cnt_d;
  logic [LOG2W:0]   beat_cnt_q, beat_cnt_d, beat_incl_w;
  logic [1:0]       load_level_q, load_level_d;
  logic             sat_flag_q, sat_flag_d;

  always_comb begin
    beat_incl_w  = beat_cnt_q + {{LOG2W{1'b0}}, accept_w};
    win_cnt_d    = win_cnt_q + 1'b1;
    beat_cnt_d   = beat_incl_w;
    load_level_d = load_level_q;
    sat_flag_d   = sat_flag_q | (accept_w & sat_w);
    if (&win_cnt_q) begin
      load_level_d = beat_incl_w[LOG2W] ? LOAD_MAX : beat_incl_w[LOG2W-1:LOG2W-2];
      beat_cnt_d   = {{LOG2W{1'b0}}, accept_w};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_cnt_q    <= '0;
      beat_cnt_q   <= '0;
      load_level_q <= 2'd0;
      sat_flag_q   <= 1'b0;
    end else begin
      win_cnt_q    <= win_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      load_level_q <= load_level_d;
      sat_flag_q   <= sat_flag_d;
    end
  end

  assign load_level = load_level_q;
  assign sat_flag   = sat_flag_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_axis_requant.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fir_axis_requant: scoreboard bench for the requant output stage       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_fir_axis_requant;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic [1:0]  m_axis_tkeep;
  logic        m_axis_tready;
  logic        sat_flag;
  logic [1:0]  load_level;

  fir_axis_requant dut (
    .clk           (clk),
    .reset         (reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tready (m_axis_tready),
    .sat_flag      (sat_flag),
    .load_level    (load_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic        l;
    int          cyc;
  } exp_t;

  exp_t        exp_q [$];
  exp_t        mon_e;
  logic [16:0] mon_r;
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  logic        lat_chk  = 1'b0;
  logic        exp_sat  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference requantiser: returns {saturated, q15}.
  function automatic logic [16:0] ref_rq(input logic [31:0] x);
    longint v;
    longint r;
    v = longint'($signed(x)) + 64'sd16384;
    r = v >>> 15;
    if (r > 64'sd32767)  return {1'b1, 16'h7FFF};
    if (r < -64'sd32768) return {1'b1, 16'h8000};
    return {1'b0, r[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      exp_sat = 1'b0;
    end else begin
      if (s_axis_tvalid && s_axis_tready) begin
        mon_r     = ref_rq(s_axis_tdata);
        mon_e.d   = mon_r[15:0];
        mon_e.l   = s_axis_tlast;
        mon_e.cyc = cyc;
        exp_q.push_back(mon_e);
        exp_sat   = exp_sat | mon_r[16];
      end
      if (m_axis_tvalid && m_axis_tready) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          failures++;
          $error("FAIL sb_underflow observed=output_beat expected=no_beat");
        end
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("out_data", m_axis_tdata, mon_e.d);
          chk("out_last", m_axis_tlast, mon_e.l);
          chk("out_keep", m_axis_tkeep, 2'b11);
          if (lat_chk) chk("latency", cyc, mon_e.cyc + 1);
        end
      end else if (!m_axis_tvalid) begin
        chk("idle_keep", m_axis_tkeep, 2'b00);
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic l);
    int n = 0;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    @(negedge clk);
    while (!s_axis_tready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (n < 100) else begin
      failures++;
      $error("FAIL send_timeout observed=%0d expected<100 cycles", n);
    end
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL drain observed=%0d expected=0 pending", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_pattern(input int period, input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      s_axis_tdata  = $urandom;
      s_axis_tlast  = (i % 16 == 15);
      s_axis_tvalid = (period != 0) ? (i % period == 0) : 1'b0;
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  logic [31:0] rnd_v [4];
  logic [31:0] sat_v [5];

  initial begin
    rnd_v = '{32'h00004000, 32'h00003FFF, 32'hFFFFC000, 32'h00008000};
    sat_v = '{32'h40000000, 32'hBFFF0000, 32'hC0000000, 32'h7FFFFFFF, 32'h80000000};

    reset         = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    #1;
    chk("rst_m_valid", m_axis_tvalid, 0);
    chk("rst_s_ready", s_axis_tready, 0);
    chk("rst_keep", m_axis_tkeep, 0);
    chk("rst_data", m_axis_tdata, 0);
    chk("rst_sat", sat_flag, 0);
    chk("rst_load", load_level, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rel_ready_low", s_axis_tready, 0);
    @(posedge clk);
    #1;
    chk("rel_ready_high", s_axis_tready, 1);

    // Rounding
    lat_chk = 1'b1;
    foreach (rnd_v[i]) send(rnd_v[i], i == 3);
    wait_drain();
    chk("round_sat", sat_flag, exp_sat);
    chk("round_sat_zero", sat_flag, 0);

    // Saturation
    send(sat_v[0], 1'b0);
    wait_drain();
    chk("sat_first", sat_flag, 1);
    for (int i = 1; i < 5; i++) send(sat_v[i], 1'b0);
    wait_drain();
    chk("sat_sticky", sat_flag, 1);

    // Backpressure: A and B fill the FIFO, C must wait
    lat_chk       = 1'b0;
    m_axis_tready = 1'b0;
    send(32'h00123456, 1'b0);
    send(32'hFF876543, 1'b0);
    s_axis_tdata  = 32'h01234567;
    s_axis_tlast  = 1'b1;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_ready", s_axis_tready, 0);
      chk("bp_valid", m_axis_tvalid, 1);
      chk("bp_hold", {m_axis_tlast, m_axis_tdata}, {exp_q[0].l, exp_q[0].d});
    end
    @(posedge clk);
    #1;
    m_axis_tready = 1'b1;
    send(32'h01234567, 1'b1);
    wait_drain();

    // Streaming
    lat_chk = 1'b1;
    for (int i = 0; i < 1000; i++) send($urandom, 1'($urandom_range(0, 1)));
    wait_drain();
    chk("stream_sat", sat_flag, exp_sat);

    // Load monitor, continuous
    run_pattern(1, 768);
    wait_drain();
    chk("load_full", load_level, 3);

    // Reset with FIFO full
    lat_chk       = 1'b0;
    m_axis_tready = 1'b0;
    send(32'h00011111, 1'b0);
    send(32'h00022222, 1'b1);
    chk("full_ready", s_axis_tready, 0);
    #3;
    reset = 1'b1;
    #2;
    chk("arst_m_valid", m_axis_tvalid, 0);
    chk("arst_load", load_level, 0);
    chk("arst_sat", sat_flag, 0);
    chk("arst_s_ready", s_axis_tready, 0);
    chk("arst_data", m_axis_tdata, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("arel_ready_low", s_axis_tready, 0);
    m_axis_tready = 1'b1;
    @(posedge clk);
    #1;
    chk("arel_ready_high", s_axis_tready, 1);
    lat_chk = 1'b1;
    send(32'h00FEDCBA, 1'b1);
    wait_drain();
    chk("post_rst_sat", sat_flag, exp_sat);

    // Load monitor, partial duty cycles and idle
    run_pattern(2, 768);
    wait_drain();
    chk("load_half", load_level, 2);
    run_pattern(4, 768);
    wait_drain();
    chk("load_quarter", load_level, 1);
    run_pattern(0, 768);
    chk("load_idle", load_level, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
